alu_issue: RTL and testbench

//   Operand-fetch / writeback stage directly upstream of the 8-bit ALU.

---
 rtl/alu_issue.sv | 109 ++++++++++
 tb/tb_alu_issue.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Operand-fetch / writeback stage feeding a combinational ALU from a small register file.
// Optional ZERO_FLAG_EN adds a registered zero_flag updated on each writeback.
module alu_issue #(
    parameter int unsigned DW    = 8,
    parameter int unsigned NREGS = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    output logic [DW-1:0] wb_data,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic [AW-1:0] host_raddr,
    output logic [DW-1:0] host_rdata
`ifdef ZERO_FLAG_EN
    ,
    output logic          zero_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] res_q;
    logic [DW-1:0] regs [NREGS];

    // Next-state decode
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand, result and register-file storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            alu_op   <= 3'b000;
            alu_a    <= '0;
            alu_b    <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
`ifdef ZERO_FLAG_EN
            zero_flag <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == IDLE);
            done     <= (state_d == WB);
            if (accept) begin
                alu_op <= in_op;
                rd_q   <= in_rd;
                alu_a  <= regs[in_rs1];
                alu_b  <= regs[in_rs2];
            end
            if (state_q == EXEC) begin
                res_q <= alu_result;
            end
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
            // Writeback is ordered after the host write so it wins on a collision
            if (state_q == WB) begin
                regs[rd_q] <= res_q;
`ifdef ZERO_FLAG_EN
                zero_flag  <= (res_q == '0);
`endif
            end
        end
    end

    assign wb_data    = res_q;
    assign host_rdata = regs[host_raddr];

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: scoreboard of expected writebacks plus a shadow register file.
`timescale 1ns/1ps
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       done;
    logic [7:0] wb_data;
    logic       host_we;
    logic [1:0] host_addr, host_raddr;
    logic [7:0] host_wdata, host_rdata;
`ifdef ZERO_FLAG_EN
    logic       zero_flag;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    logic [7:0] mregs [4];
    logic [7:0] sb_q [$];

    alu_issue #(.DW(8), .NREGS(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .done(done), .wb_data(wb_data),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata)
`ifdef ZERO_FLAG_EN
        , .zero_flag(zero_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    // Combinational ALU environment
    always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic host_write(input logic [1:0] a, input logic [7:0] d, input bit upd);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        if (upd) mregs[a] = d;
    endtask

    // Drive one instruction at a negedge while in_ready is high; returns at the EXEC negedge
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        sb_q.push_back(alu_f(op, mregs[rs1], mregs[rs2]));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Bounded wait for done; returns at the negedge where done is seen
    task automatic wait_done(output logic [7:0] d, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        d  = 8'h00;
        while (!ok && n < 10) begin
            if (done === 1'b1) begin
                d  = wb_data;
                ok = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || alu_op !== 3'd0 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b done=%b op=%h a=%h b=%h exp 1 0 0 00 00",
                     in_ready, done, alu_op, alu_a, alu_b);
        end
        for (int i = 0; i < 4; i++) begin
            host_raddr = 2'(i);
            #1;
            checks++;
            if (host_rdata !== 8'h00) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=00", i, host_rdata);
            end
            mregs[i] = 8'h00;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [7:0] d, e;
        int n;
        bit ok;
        host_write(2'd1, 8'h05, 1'b1);
        host_write(2'd2, 8'h03, 1'b1);
        issue(3'd0, 2'd3, 2'd1, 2'd2);
        checks++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 3'd0) begin
            failures++;
            $display("FAIL add_operands got op=%h a=%h b=%h exp 0 05 03", alu_op, alu_a, alu_b);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_ready_exec got=%b exp=0", in_ready);
        end
        wait_done(d, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || d !== e) begin
            failures++;
            $display("FAIL add_wb got=%h ok=%b exp=%h", d, ok, e);
        end
        checks++;
        if (n !== 1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_latency got=%0d ready=%b exp=1 0", n, in_ready);
        end
        mregs[3] = e;
        @(negedge clk);
        host_raddr = 2'd3;
        #1;
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || host_rdata !== 8'h08) begin
            failures++;
            $display("FAIL add_after got ready=%b done=%b r3=%h exp 1 0 08", in_ready, done, host_rdata);
        end
`ifdef ZERO_FLAG_EN
        checks++;
        if (zero_flag !== 1'b0) begin
            failures++;
            $display("FAIL zf_nonzero got=%b exp=0", zero_flag);
        end
`endif
    endtask

    task automatic test_sub_dep();
        logic [7:0] d, e;
        int n;
        bit ok;
        host_write(2'd1, 8'h00, 1'b1);
        host_write(2'd2, 8'h01, 1'b1);
        issue(3'd1, 2'd0, 2'd1, 2'd2);
        wait_done(d, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || d !== e || d !== 8'hFF) begin
            failures++;
            $display("FAIL sub_wrap got=%h ok=%b exp=%h", d, ok, e);
        end
        mregs[0] = e;
        @(negedge clk);
        issue(3'd4, 2'd1, 2'd0, 2'd0);
        wait_done(d, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || d !== e) begin
            failures++;
            $display("FAIL not_dep got=%h ok=%b exp=%h", d, ok, e);
        end
        mregs[1] = e;
        @(negedge clk);
        host_raddr = 2'd1;
        #1;
        checks++;
        if (host_rdata !== mregs[1]) begin
            failures++;
            $display("FAIL not_dep_reg got=%h exp=%h", host_rdata, mregs[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3] = '{3'd0, 3'd7, 3'd2};
        logic [1:0] rds [3] = '{2'd3, 2'd0, 2'd1};
        logic [1:0] s1s [3] = '{2'd0, 2'd1, 2'd2};
        logic [1:0] s2s [3] = '{2'd1, 2'd2, 2'd2};
        int acc [3];
        logic [7:0] d, e;
        int n, t;
        bit ok;
        host_write(2'd0, 8'h10, 1'b1);
        host_write(2'd1, 8'h20, 1'b1);
        host_write(2'd2, 8'h30, 1'b1);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_op  = ops[k];
            in_rd  = rds[k];
            in_rs1 = s1s[k];
            in_rs2 = s2s[k];
            sb_q.push_back(alu_f(ops[k], mregs[s1s[k]], mregs[s2s[k]]));
            t = 0;
            while (in_ready !== 1'b1 && t < 10) begin
                if (done === 1'b1) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (wb_data !== e) begin
                        failures++;
                        $display("FAIL b2b_wb got=%h exp=%h", wb_data, e);
                    end
                end
                @(negedge clk);
                t++;
            end
            acc[k] = cyc_cnt;
            @(negedge clk);
            if (k == 2) in_valid = 1'b0;
        end
        wait_done(d, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || d !== e) begin
            failures++;
            $display("FAIL b2b_last got=%h ok=%b exp=%h", d, ok, e);
        end
        checks++;
        if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc[1] - acc[0], acc[2] - acc[1]);
        end
        @(negedge clk);
        mregs[3] = 8'h30;
        mregs[0] = 8'h00;
        mregs[1] = 8'h30;
        for (int i = 0; i < 4; i++) begin
            host_raddr = 2'(i);
            #1;
            checks++;
            if (host_rdata !== mregs[i]) begin
                failures++;
                $display("FAIL b2b_reg%0d got=%h exp=%h", i, host_rdata, mregs[i]);
            end
        end
    endtask

    task automatic test_host_collide();
        logic [7:0] d, e;
        int n;
        bit ok;
        host_write(2'd1, 8'h50, 1'b1);
        host_write(2'd2, 8'h05, 1'b1);
        issue(3'd0, 2'd3, 2'd1, 2'd2);
        wait_done(d, n, ok);
        e = sb_q.pop_front();
        mregs[3] = e;
        host_write(2'd3, 8'hAA, 1'b0);
        host_raddr = 2'd3;
        #1;
        checks++;
        if (!ok || host_rdata !== 8'h55) begin
            failures++;
            $display("FAIL wb_wins got=%h exp=55", host_rdata);
        end
        // Host write to r2 on the accepting edge: operand must see the old r2
        in_valid = 1'b1;
        in_op = 3'd0; in_rd = 2'd0; in_rs1 = 2'd1; in_rs2 = 2'd2;
        sb_q.push_back(alu_f(3'd0, mregs[1], mregs[2]));
        host_write(2'd2, 8'h77, 1'b1);
        in_valid = 1'b0;
        checks++;
        if (alu_b !== 8'h05) begin
            failures++;
            $display("FAIL host_accept_old got=%h exp=05", alu_b);
        end
        wait_done(d, n, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || d !== e) begin
            failures++;
            $display("FAIL host_accept_wb got=%h exp=%h", d, e);
        end
        mregs[0] = e;
        @(negedge clk);
        host_raddr = 2'd2;
        #1;
        checks++;
        if (host_rdata !== 8'h77) begin
            failures++;
            $display("FAIL host_r2 got=%h exp=77", host_rdata);
        end
    endtask

`ifdef ZERO_FLAG_EN
    task automatic test_zero_flag();
        logic [7:0] d, e;
        int n;
        bit ok;
        host_write(2'd1, 8'h05, 1'b1);
        issue(3'd1, 2'd0, 2'd1, 2'd1);
        wait_done(d, n, ok);
        e = sb_q.pop_front();
        mregs[0] = e;
        @(negedge clk);
        checks++;
        if (!ok || zero_flag !== 1'b1) begin
            failures++;
            $display("FAIL zf_zero got=%b exp=1", zero_flag);
        end
    endtask
`endif

    task automatic test_reset_exec();
        int seen;
        host_write(2'd1, 8'h21, 1'b1);
        issue(3'd0, 2'd2, 2'd1, 2'd1);
        void'(sb_q.pop_front());
        rst_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_exec got done=%b ready=%b exp 0 1", done, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_no_done got=%0d exp=0", seen);
        end
        host_raddr = 2'd2;
        #1;
        checks++;
        if (host_rdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_rd got=%h exp=00", host_rdata);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_op = 3'd0; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0;
        host_we = 1'b0; host_addr = 2'd0; host_wdata = 8'h00; host_raddr = 2'd0;
        test_reset();
        test_add();
        test_sub_dep();
        test_back_to_back();
        test_host_collide();
`ifdef ZERO_FLAG_EN
        test_zero_flag();
`endif
        test_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
